// File: rtl/inst_memory_if.sv
// inst_memory_if -- fetch and program-load bus for the instruction memory.
//
// Signals:
//   pc          [15:0]  byte address of the instruction to fetch
//   instruction [15:0]  instruction word at pc (combinational, always valid)
//   we                  program-load write enable
//   waddr       [15:0]  byte address of the program-load write
//   wdata       [15:0]  instruction word to write
//
// Modports:
//   master -- the fetch/loader side (drives pc, we, waddr, wdata)
//   slave  -- the memory itself (drives instruction)
interface inst_memory_if;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic        we;
  logic [15:0] waddr;
  logic [15:0] wdata;

  modport master (
    output pc,
    output we,
    output waddr,
    output wdata,
    input  instruction
  );

  modport slave (
    input  pc,
    input  we,
    input  waddr,
    input  wdata,
    output instruction
  );
endinterface

// File: rtl/inst_memory.sv
// inst_memory -- 2^DEPTH_LOG2 x 16-bit instruction store.
//
// Ports:
//   clk  -- single clock, all state changes on its rising edge
//   rst  -- synchronous active-high reset; reloads the default program image
//   bus  -- inst_memory_if.slave: pc/instruction fetch port (combinational
//           read) and we/waddr/wdata program-load write port
//
// Addresses are byte addresses with instructions on 4-byte boundaries: the
// word index is addr[DEPTH_LOG2+1:2]; the low two bits and the bits above the
// index are ignored, so addresses wrap modulo 4*2^DEPTH_LOG2.
module inst_memory #(
  parameter int DEPTH_LOG2 = 8
) (
  input logic         clk,
  input logic         rst,
  inst_memory_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Boot program; also the contents restored by reset.
  localparam logic [15:0] IMAGE [DEPTH] = '{
    0:       16'h0400,
    1:       16'h0441,
    2:       16'h2050,
    3:       16'h1280,
    4:       16'h3050,
    5:       16'h4050,
    default: 16'h0000
  };

  // Initialised at declaration so the image is present from time zero
  // without needing a reset.
  logic [15:0] mem [DEPTH] = IMAGE;

  logic [DEPTH_LOG2-1:0] ridx;
  logic [DEPTH_LOG2-1:0] widx;

  assign ridx = bus.pc[DEPTH_LOG2+1:2];
  assign widx = bus.waddr[DEPTH_LOG2+1:2];

  // Byte-offset and wrap bits carry no information for this memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.pc[15:DEPTH_LOG2+2], bus.pc[1:0],
                              bus.waddr[15:DEPTH_LOG2+2], bus.waddr[1:0]};

  // Reset wins over a simultaneous write: the write is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= IMAGE;
    end else if (bus.we) begin
      mem[widx] <= bus.wdata;
    end
  end

  // Zero-latency fetch: reflects the current pc and contents, including
  // during reset (old contents until the reset edge).
  assign bus.instruction = mem[ridx];

endmodule

// File: tb/tb_inst_memory.sv
// tb_inst_memory -- self-checking bench for inst_memory.
// Directed steps followed by randomized load/reset/fetch traffic, all checked
// against a word-array reference model of the memory.
module tb_inst_memory;

  logic clk = 1'b0;
  logic rst = 1'b0;

  inst_memory_if bus ();

  inst_memory #(.DEPTH_LOG2(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] model [256];

  function automatic logic [15:0] boot_word(input int i);
    case (i)
      0:       return 16'h0400;
      1:       return 16'h0441;
      2:       return 16'h2050;
      3:       return 16'h1280;
      4:       return 16'h3050;
      5:       return 16'h4050;
      default: return 16'h0000;
    endcase
  endfunction

  // Byte address -> word slot: 4 bytes per instruction, 1024-byte wrap.
  function automatic int slot(input logic [15:0] a);
    return (int'(a) / 4) % 256;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model[i] = boot_word(i);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Fetch only: inputs change on the falling edge, sampled 1 time unit later.
  task automatic rd(input logic [15:0] a, input string tag);
    @(negedge clk);
    rst = 1'b0;
    we  = 1'b0;
    bus.pc = a;
    #1;
    check(tag, bus.instruction, model[slot(a)]);
  endtask

  // One clocked step: check the pre-edge fetch (old contents), take the edge,
  // update the model, check the post-edge fetch. Inputs stay asserted until
  // the next step so consecutive resets are contiguous.
  task automatic cycle(input logic r, input logic w, input logic [15:0] wa,
                       input logic [15:0] wd, input logic [15:0] p, input string tag);
    @(negedge clk);
    rst       = r;
    we        = w;
    bus.waddr = wa;
    bus.wdata = wd;
    bus.pc    = p;
    #1;
    check({tag, "_pre"}, bus.instruction, model[slot(p)]);
    @(posedge clk);
    if (r) model_reset();
    else if (w) model[slot(wa)] = wd;
    #1;
    check({tag, "_post"}, bus.instruction, model[slot(p)]);
  endtask

  logic we;
  assign bus.we = we;

  initial begin
    we        = 1'b0;
    bus.pc    = 16'h0000;
    bus.waddr = 16'h0000;
    bus.wdata = 16'h0000;
    model_reset();

    // Image present before any clock edge or reset.
    #1;
    check("t0_word0", bus.instruction, 16'h0400);

    // Default fetch sequence.
    rd(16'd0,  "dflt_pc0");
    rd(16'd4,  "dflt_pc4");
    rd(16'd8,  "dflt_pc8");
    rd(16'd12, "dflt_pc12");
    rd(16'd16, "dflt_pc16");
    rd(16'd20, "dflt_pc20");
    check("dflt_pc20_const", bus.instruction, 16'h4050);

    // Alignment and wrap.
    rd(16'd5,     "misaligned_pc5");
    check("misaligned_pc5_const", bus.instruction, 16'h0441);
    rd(16'd24,    "pc24_zero");
    rd(16'h0404,  "wrap_pc404");
    check("wrap_pc404_const", bus.instruction, 16'h0441);
    rd(16'hFFFF,  "wrap_pcFFFF");

    // Write then read; pre-edge shows the old word.
    cycle(1'b0, 1'b1, 16'd8, 16'hBEEF, 16'd8, "wr_beef");
    rd(16'd8, "after_wr_pc8");
    check("after_wr_pc8_const", bus.instruction, 16'hBEEF);
    rd(16'd4, "after_wr_pc4");
    check("after_wr_pc4_const", bus.instruction, 16'h0441);

    // Misaligned, wrapped write address lands on word 3.
    cycle(1'b0, 1'b1, 16'h040D, 16'hA5A5, 16'd12, "wr_wrap");
    check("wr_wrap_const", bus.instruction, 16'hA5A5);

    // Reset restore; during reset the written word is still visible.
    cycle(1'b1, 1'b0, 16'd0, 16'd0, 16'd8, "rst_restore");
    rd(16'd8, "rst_pc8");
    check("rst_pc8_const", bus.instruction, 16'h2050);

    // Reset priority over a simultaneous write.
    cycle(1'b1, 1'b1, 16'd0, 16'h1234, 16'd0, "rst_prio");
    rd(16'd0, "prio_pc0");
    check("prio_pc0_const", bus.instruction, 16'h0400);

    // Multi-cycle reset after scattering writes.
    cycle(1'b0, 1'b1, 16'd100, 16'h1111, 16'd100, "mc_wr0");
    cycle(1'b0, 1'b1, 16'd20,  16'h2222, 16'd20,  "mc_wr1");
    cycle(1'b1, 1'b0, 16'd0, 16'd0, 16'd20, "mc_rst0");
    cycle(1'b1, 1'b1, 16'd20, 16'h3333, 16'd20, "mc_rst1");
    cycle(1'b1, 1'b0, 16'd0, 16'd0, 16'd100, "mc_rst2");
    for (int i = 0; i < 256; i++) rd(16'(i * 4), "full_image");

    // Randomized load/reset/fetch traffic.
    for (int n = 0; n < 400; n++) begin
      logic r, w;
      logic [15:0] wa, wd, p;
      r  = ($urandom_range(0, 15) == 0);
      w  = $urandom_range(0, 1) != 0;
      wa = 16'($urandom);
      wd = 16'($urandom);
      p  = ($urandom_range(0, 1) != 0) ? wa : 16'($urandom);
      cycle(r, w, wa, wd, p, "rand");
    end
    for (int i = 0; i < 256; i++) rd(16'(i * 4 + $urandom_range(0, 3)), "rand_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
